// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified DAC transmitter with a one-pair holding buffer.
// All serial outputs change on the master-clock cycle of a BCLK fall event.
module audio_i2s_tx #(
    parameter int SAMPLE_W        = 16,
    parameter int SLOT_W          = 32,
    parameter int BCLK_DIV        = 2,
    parameter int FORMAT          = 0,
    parameter int UNDERRUN_REPEAT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                frame_start,
    output logic                underrun
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int PW    = $clog2(FRAME);
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0]       div_q;
    logic                bclk_q;
    logic [PW-1:0]       p_q;
    logic                hold_full_q;
    logic [SAMPLE_W-1:0] hold_l_q, hold_r_q;
    logic [SAMPLE_W-1:0] frm_l_q, frm_r_q;
    logic                lrck_q, dat_q, fs_q, ur_q;

    logic                tick, fall, load, accept, right;
    logic [PW-1:0]       p_d, k;
    logic [SAMPLE_W-1:0] frm_l_d, frm_r_d, sample, sh;
    logic                dat_d, lrck_d;

    always_comb begin
        tick    = (div_q == DW'(BCLK_DIV - 1));
        fall    = tick && bclk_q;
        load    = fall && (p_q == PW'(FRAME - 1));
        accept  = in_valid && !hold_full_q;
        p_d     = load ? '0 : p_q + 1'b1;
        frm_l_d = frm_l_q;
        frm_r_d = frm_r_q;
        if (load) begin
            if (hold_full_q) begin
                frm_l_d = hold_l_q;
                frm_r_d = hold_r_q;
            end else if (UNDERRUN_REPEAT == 0) begin
                frm_l_d = '0;
                frm_r_d = '0;
            end
        end
        // Serial bit for the position we are about to enter, taken from the
        // frame as it will be after this clk (so a load shows the new left MSB).
        right  = (p_d >= PW'(SLOT_W));
        k      = right ? p_d - PW'(SLOT_W) : p_d;
        sample = right ? frm_r_d : frm_l_d;
        sh     = sample << k;
        dat_d  = (k < PW'(SAMPLE_W)) && sh[SAMPLE_W-1];
        if (FORMAT != 0) lrck_d = right;
        else             lrck_d = (p_d >= PW'(SLOT_W - 1)) && (p_d != PW'(FRAME - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            p_q         <= PW'(FRAME - 1);
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            frm_l_q     <= '0;
            frm_r_q     <= '0;
            lrck_q      <= (FORMAT != 0);
            dat_q       <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) bclk_q <= ~bclk_q;
            fs_q <= load;
            ur_q <= load && !hold_full_q;
            if (fall) begin
                p_q    <= p_d;
                lrck_q <= lrck_d;
                dat_q  <= dat_d;
            end
            if (load) begin
                frm_l_q <= frm_l_d;
                frm_r_q <= frm_r_d;
            end
            // No bypass: a pair accepted on a load clk waits for the next frame.
            if (load && hold_full_q) begin
                hold_full_q <= 1'b0;
            end else if (accept) begin
                hold_full_q <= 1'b1;
                hold_l_q    <= in_left;
                hold_r_q    <= in_right;
            end
        end
    end

    assign in_ready    = !hold_full_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Two configurations of audio_i2s_tx decoded like a codec and checked against
// a scoreboard of accepted pairs / fallback frames.
module tb_audio_i2s_tx;
    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    int checks   = 0;
    int failures = 0;
    bit done[2];

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          cyc;
    } pair_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int SW    = g ? 24 : 16;
        localparam int SL    = g ? 24 : 32;
        localparam int DV    = g ? 3 : 2;
        localparam int FM    = g;
        localparam int RP    = g;
        localparam int FRAME = 4 * SL * DV;

        logic        rst_n, vld, rdy, bclk, lrck, dat, fs, ur;
        logic [31:0] lft, rgt;

        audio_i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(DV),
                       .FORMAT(FM), .UNDERRUN_REPEAT(RP)) dut (
            .clk(gclk), .reset(rst_n),
            .in_left(lft[SW-1:0]), .in_right(rgt[SW-1:0]),
            .in_valid(vld), .in_ready(rdy),
            .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
            .frame_start(fs), .underrun(ur));

        pair_t       accq[$];
        pair_t       expq[$];
        int          cyc = 0, rel = 0;
        int          last_rise, last_fs, b;
        logic [31:0] capl, capr, last_l, last_r;
        logic        lr_err, pad_err, bclk_prev;

        always @(posedge gclk) begin
            if (rst_n && vld && rdy) accq.push_back('{lft, rgt, cyc});
            rel = rst_n ? rel + 1 : 0;
            cyc++;
        end

        always @(negedge gclk) begin : mon
            pair_t e;
            bit    elig;
            int    k;
            logic  exp_lr;
            elig = 0;
            if (!rst_n) begin
                accq.delete(); expq.delete();
                b = -1; last_rise = -1; last_fs = -1;
                last_l = '0; last_r = '0; bclk_prev = 1'b0;
            end else begin
                if (fs) begin
                    if (last_fs < 0) chk("first_fs", rel, 2 * DV);
                    else             chk("fs_period", rel - last_fs, FRAME);
                    last_fs = rel;
                    if (b == 2 * SL) begin
                        chk("sb_depth", expq.size(), 1);
                        if (expq.size() > 0) begin
                            e = expq.pop_front();
                            chk("left", capl, e.l);
                            chk("right", capr, e.r);
                            chk("lrck", lr_err, 0);
                            chk("pad", pad_err, 0);
                        end
                    end
                    // The load clk is the posedge just before this negedge.
                    elig = (accq.size() > 0) && (accq[0].cyc < cyc - 1);
                    if (elig) e = accq.pop_front();
                    else begin
                        e.l = RP ? last_l : '0;
                        e.r = RP ? last_r : '0;
                        e.cyc = 0;
                    end
                    last_l = e.l; last_r = e.r;
                    expq.push_back(e);
                    b = 0; capl = '0; capr = '0; lr_err = 0; pad_err = 0;
                end
                chk("underrun", ur, (fs && !elig) ? 1 : 0);
                if (bclk && !bclk_prev) begin
                    if (last_rise < 0) chk("first_rise", rel, DV);
                    else               chk("bclk_period", rel - last_rise, 2 * DV);
                    last_rise = rel;
                    if (b >= 0 && b < 2 * SL) begin
                        k      = (b < SL) ? b : b - SL;
                        exp_lr = FM ? (b >= SL) : (((b + 1) % (2 * SL)) >= SL);
                        if (lrck !== exp_lr) lr_err = 1;
                        if (k < SW) begin
                            if (b < SL) capl = {capl[30:0], dat};
                            else        capr = {capr[30:0], dat};
                        end else if (dat !== 1'b0) pad_err = 1;
                        b++;
                    end
                end
                bclk_prev = bclk;
                chk("in_ready", rdy, (accq.size() == 0) ? 1 : 0);
            end
        end

        task automatic rst_vals(input string tag);
            chk({tag, "_bclk"}, bclk, 0);
            chk({tag, "_dat"}, dat, 0);
            chk({tag, "_lrck"}, lrck, FM);
            chk({tag, "_rdy"}, rdy, 1);
            chk({tag, "_fs"}, fs, 0);
            chk({tag, "_ur"}, ur, 0);
        endtask

        task automatic send(input logic [31:0] l, input logic [31:0] r);
            bit ok;
            ok = 0;
            lft = l; rgt = r; vld = 1'b1;
            for (int t = 0; t < 3 * FRAME && !ok; t++) begin
                if (rdy) ok = 1;
                @(posedge gclk); #1;
            end
            if (!ok) chk("send_timeout", 0, 1);
        endtask

        initial begin
            bit seen;
            rst_n = 1'b0; vld = 1'b0; lft = '0; rgt = '0;
            repeat (3) @(posedge gclk);
            #1;
            rst_vals("reset");
            // One pair ready before the first frame, then idle.
            rst_n = 1'b1;
            lft = g ? 32'h800001 : 32'hA5C3;
            rgt = g ? 32'h7FFFFE : 32'h8001;
            vld = 1'b1;
            @(posedge gclk); #1;
            vld = 1'b0;
            repeat (2 * FRAME) @(posedge gclk);
            #1;
            // Back-to-back stream; last pair is the one repeated on underrun.
            for (int i = 0; i < 3; i++) send(32'h00C0 + i, 32'h0F00 + 3 * i);
            send(32'h1234, 32'h5678);
            vld = 1'b0;
            repeat (3 * FRAME) @(posedge gclk);
            #1;
            // Park a pair in the buffer, then reset in the middle of the right slot.
            seen = 0;
            for (int t = 0; t < 2 * FRAME && !seen; t++) begin
                if (fs) seen = 1;
                else begin @(posedge gclk); #1; end
            end
            if (!seen) chk("fs_timeout", 0, 1);
            send(32'h00AB, 32'h00CD);
            vld = 1'b0;
            repeat (FRAME * 3 / 4 - 4) @(posedge gclk);
            #1;
            rst_n = 1'b0;
            @(posedge gclk); #1;
            rst_vals("midrst");
            repeat (2) @(posedge gclk);
            #1;
            rst_n = 1'b1;
            repeat (2 * FRAME + 4 * DV) @(posedge gclk);
            #1;
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 40000 && !(done[0] && done[1]); t++) @(posedge gclk);
        if (!(done[0] && done[1])) chk("run_timeout", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
